// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and state encodings for the router packet controller
package router_pkg;

    localparam int NUM_PORTS = 3;

    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t WAIT_TILL_EMPTY    = 3'd1;
    localparam state_t LOAD_FIRST_DATA    = 3'd2;
    localparam state_t LOAD_DATA          = 3'd3;
    localparam state_t FIFO_FULL_STATE    = 3'd4;
    localparam state_t LOAD_AFTER_FULL    = 3'd5;
    localparam state_t LOAD_PARITY        = 3'd6;
    localparam state_t CHECK_PARITY_ERROR = 3'd7;

    // Only addresses 0..NUM_PORTS-1 name a real FIFO.
    function automatic logic addr_legal(input logic [1:0] addr);
        return addr != ADDR_ILLEGAL;
    endfunction

endpackage

// File: rtl/router_pkt_ctrl.sv
// rtl/router_pkt_ctrl.sv - Moore FSM sequencing header, payload and parity writes into the port FIFOs
module router_pkt_ctrl
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t     state;
    state_t     state_next;
    logic [1:0] addr;
    logic       hdr_empty;
    logic       addr_empty;
    logic       addr_soft_reset;
    logic       hdr_accept;

    // A header is taken only when a packet is present and it names a real port.
    assign hdr_accept = (state == DECODE_ADDRESS) && pkt_valid && addr_legal(data_in);

    // Empty flag of the port named by the incoming header byte.
    always_comb begin
        hdr_empty = 1'b0;
        case (data_in)
            ADDR_0:  hdr_empty = fifo_empty_0;
            ADDR_1:  hdr_empty = fifo_empty_1;
            ADDR_2:  hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    // Empty flag and soft reset of the port latched for the packet in flight.
    always_comb begin
        addr_empty      = 1'b0;
        addr_soft_reset = 1'b0;
        case (addr)
            ADDR_0: begin
                addr_empty      = fifo_empty_0;
                addr_soft_reset = soft_reset_0;
            end
            ADDR_1: begin
                addr_empty      = fifo_empty_1;
                addr_soft_reset = soft_reset_1;
            end
            ADDR_2: begin
                addr_empty      = fifo_empty_2;
                addr_soft_reset = soft_reset_2;
            end
            default: begin
                addr_empty      = 1'b0;
                addr_soft_reset = 1'b0;
            end
        endcase
    end

    // Next-state logic; a soft reset of the active port aborts any packet phase.
    always_comb begin
        state_next = DECODE_ADDRESS;
        if (state != DECODE_ADDRESS && addr_soft_reset) begin
            state_next = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (hdr_accept)
                        state_next = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    else
                        state_next = DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY:
                    state_next = addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:
                    state_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        state_next = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_next = LOAD_PARITY;
                    else
                        state_next = LOAD_DATA;
                end
                FIFO_FULL_STATE:
                    state_next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_next = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_next = LOAD_PARITY;
                    else
                        state_next = LOAD_DATA;
                end
                LOAD_PARITY:
                    state_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:
                    state_next = DECODE_ADDRESS;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn)
            state <= DECODE_ADDRESS;
        else
            state <= state_next;
    end

    // Address register holds the destination of the packet in flight.
    always_ff @(posedge clock) begin
        if (!resetn)
            addr <= ADDR_0;
        else if (hdr_accept)
            addr <= data_in;
    end

    // Moore output decode.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state)
            DECODE_ADDRESS: detect_add = 1'b1;
            WAIT_TILL_EMPTY: busy = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            default: detect_add = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// tb/tb_router_pkt_ctrl.sv - vector table and scoreboard bench for router_pkt_ctrl
module tb_router_pkt_ctrl;

    // Output bundle order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] O_DA  = 8'h80;
    localparam logic [7:0] O_WTE = 8'h01;
    localparam logic [7:0] O_LFD = 8'h41;
    localparam logic [7:0] O_LD  = 8'h24;
    localparam logic [7:0] O_FUL = 8'h09;
    localparam logic [7:0] O_LAF = 8'h15;
    localparam logic [7:0] O_LP  = 8'h05;
    localparam logic [7:0] O_CPE = 8'h03;

    typedef struct {
        logic       rn;
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1;
    logic       fifo_empty_1 = 1'b1;
    logic       fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0;
    logic       soft_reset_1 = 1'b0;
    logic       soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    vec_t       vq[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         fails = 0;

    router_pkt_ctrl dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    task automatic add(input logic rn, input logic pv, input logic [1:0] din, input logic ff,
                       input logic [2:0] emp, input logic [2:0] sr, input logic pd,
                       input logic lpv, input logic [7:0] e);
        vec_t v;
        v.rn = rn; v.pv = pv; v.din = din; v.ff = ff; v.emp = emp;
        v.sr = sr; v.pd = pd; v.lpv = lpv; v.exp = e;
        vq.push_back(v);
    endtask

    // Drive one vector, clock it, then compare against the scoreboard head.
    task automatic apply(input int idx, output logic [7:0] got);
        logic [7:0] e;
        resetn = vq[idx].rn; pkt_valid = vq[idx].pv; data_in = vq[idx].din;
        fifo_full = vq[idx].ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = vq[idx].emp;
        {soft_reset_2, soft_reset_1, soft_reset_0} = vq[idx].sr;
        parity_done = vq[idx].pd; low_pkt_valid = vq[idx].lpv;
        exp_q.push_back(vq[idx].exp);
        @(posedge clock);
        #1;
        got = outs();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            fails++;
            $display("FAIL vec%0d outputs got %h expected %h", idx, got, e);
        end
    endtask

    initial begin
        logic [7:0] got;
        int         we_count;

        //  rn pv din ff  emp     sr     pd lpv exp
        add(0, 0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA);   // 0  reset
        add(1, 0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA);   // 1  idle
        // Empty FIFO 1, four-cycle packet
        add(1, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_LFD);  // 2
        add(1, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_LD);   // 3
        add(1, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_LD);   // 4
        add(1, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_LD);   // 5
        add(1, 0, 1, 0, 3'b010, 3'b000, 0, 0, O_LP);   // 6
        add(1, 0, 1, 0, 3'b010, 3'b000, 0, 0, O_CPE);  // 7
        add(1, 0, 1, 0, 3'b010, 3'b000, 0, 0, O_DA);   // 8
        // Illegal header stays in decode
        add(1, 1, 3, 0, 3'b111, 3'b000, 0, 0, O_DA);   // 9
        // Port 2 busy, wait until it drains
        add(1, 1, 2, 0, 3'b011, 3'b000, 0, 0, O_WTE);  // 10
        add(1, 1, 2, 0, 3'b011, 3'b000, 0, 0, O_WTE);  // 11
        add(1, 1, 2, 0, 3'b111, 3'b000, 0, 0, O_LFD);  // 12
        add(1, 1, 2, 0, 3'b111, 3'b000, 0, 0, O_LD);   // 13
        // Full stall for three cycles, then low_pkt_valid
        add(1, 1, 2, 1, 3'b111, 3'b000, 0, 0, O_FUL);  // 14
        add(1, 1, 2, 1, 3'b111, 3'b000, 0, 0, O_FUL);  // 15
        add(1, 1, 2, 1, 3'b111, 3'b000, 0, 0, O_FUL);  // 16
        add(1, 0, 2, 0, 3'b111, 3'b000, 0, 0, O_LAF);  // 17
        add(1, 0, 2, 0, 3'b111, 3'b000, 0, 1, O_LP);   // 18
        add(1, 0, 2, 0, 3'b111, 3'b000, 0, 0, O_CPE);  // 19
        add(1, 0, 2, 1, 3'b111, 3'b000, 0, 0, O_FUL);  // 20 full after parity check
        add(1, 0, 2, 0, 3'b111, 3'b000, 0, 0, O_LAF);  // 21
        add(1, 0, 2, 0, 3'b111, 3'b000, 1, 1, O_DA);   // 22 parity_done beats low_pkt_valid
        // Soft reset while waiting on port 0
        add(1, 1, 0, 0, 3'b110, 3'b000, 0, 0, O_WTE);  // 23
        add(1, 1, 0, 0, 3'b110, 3'b010, 0, 0, O_WTE);  // 24 other port ignored
        add(1, 1, 0, 0, 3'b110, 3'b001, 0, 0, O_DA);   // 25
        add(1, 0, 1, 0, 3'b111, 3'b000, 0, 0, O_DA);   // 26 no packet
        // Soft reset beats full in LOAD_DATA
        add(1, 1, 2, 0, 3'b100, 3'b000, 0, 0, O_LFD);  // 27
        add(1, 1, 2, 0, 3'b100, 3'b000, 0, 0, O_LD);   // 28
        add(1, 0, 2, 1, 3'b100, 3'b100, 0, 0, O_DA);   // 29
        // Full beats pkt_valid low; LAF returns to LOAD_DATA
        add(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, O_LFD);  // 30
        add(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, O_LD);   // 31
        add(1, 0, 0, 1, 3'b001, 3'b000, 0, 0, O_FUL);  // 32
        add(1, 1, 0, 0, 3'b001, 3'b000, 0, 0, O_LAF);  // 33
        add(1, 1, 0, 0, 3'b001, 3'b110, 0, 0, O_LD);   // 34 foreign soft resets ignored
        add(1, 0, 0, 0, 3'b001, 3'b000, 0, 0, O_LP);   // 35
        add(1, 0, 0, 0, 3'b001, 3'b000, 0, 0, O_CPE);  // 36
        add(1, 0, 0, 0, 3'b001, 3'b000, 0, 0, O_DA);   // 37

        we_count = 0;
        for (int i = 0; i < vq.size(); i++) begin
            apply(i, got);
            if (i >= 2 && i <= 8 && got[2]) we_count++;
        end
        checks++;
        if (we_count != 4) begin
            fails++;
            $display("FAIL we_pulses got %0d expected 4", we_count);
        end

        // Reset mid-packet: no write strobe afterwards, address back to port 0.
        vq.delete();
        add(1, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_LFD);
        add(1, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_LD);
        add(0, 1, 1, 0, 3'b010, 3'b000, 0, 0, O_DA);
        add(1, 0, 1, 0, 3'b010, 3'b000, 0, 0, O_DA);
        add(1, 0, 1, 0, 3'b010, 3'b000, 0, 0, O_DA);
        for (int i = 0; i < vq.size(); i++) begin
            apply(i, got);
            if (i >= 2) begin
                checks++;
                if (write_enb_reg !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_abort_we step%0d got %b expected 0", i, write_enb_reg);
                end
            end
        end

        // Stale packet on port 1 must not be woken by port 1 after reset: start on port 0 busy.
        vq.delete();
        add(1, 1, 0, 0, 3'b110, 3'b000, 0, 0, O_WTE);
        add(1, 1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD);
        for (int i = 0; i < vq.size(); i++) apply(i, got);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/router_pkt_ctrl.md
ROUTER_PKT_CTRL -- requirements
Module: router_pkt_ctrl

Interface
REQ-001 Parameters: none; port count fixed at 3, address width fixed at 2.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 pkt_valid  input  1  packet in progress on the input bus.
REQ-005 data_in  input  2  destination address bits of the header byte.
REQ-006 fifo_full  input  1  full flag of the currently addressed FIFO.
REQ-007 fifo_empty_0/1/2  input  1 each  empty flags of FIFO 0/1/2.
REQ-008 soft_reset_0/1/2  input  1 each  per-FIFO read-timeout soft resets.
REQ-009 parity_done  input  1  parity byte already written.
REQ-010 low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-011 detect_add  output  1  header decode cycle; downstream latches data_in.
REQ-012 lfd_state  output  1  load-first-data (header write) cycle.
REQ-013 ld_state  output  1  payload load cycle.
REQ-014 laf_state  output  1  load-after-full cycle.
REQ-015 full_state  output  1  stalled on full FIFO.
REQ-016 write_enb_reg  output  1  FIFO write qualifier.
REQ-017 rst_int_reg  output  1  parity check strobe.
REQ-018 busy  output  1  source must hold input data.

Function
REQ-019 Moore FSM with states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR; all outputs decoded from state only.
REQ-020 Output decode: DECODE_ADDRESS detect_add=1, busy=0; LOAD_FIRST_DATA lfd_state=1, busy=1; LOAD_DATA ld_state=1, write_enb_reg=1, busy=0; FIFO_FULL_STATE full_state=1, busy=1; LOAD_AFTER_FULL laf_state=1, write_enb_reg=1, busy=1; LOAD_PARITY write_enb_reg=1, busy=1; CHECK_PARITY_ERROR rst_int_reg=1, busy=1; WAIT_TILL_EMPTY busy=1; all unlisted outputs 0.
REQ-021 A 2-bit address register captures data_in on the clock edge where state=DECODE_ADDRESS and pkt_valid=1; it selects fifo_empty_k and soft_reset_k afterwards.
REQ-022 DECODE_ADDRESS: pkt_valid=1, data_in=k (k<3), fifo_empty_k=1 -> LOAD_FIRST_DATA; fifo_empty_k=0 -> WAIT_TILL_EMPTY; data_in=3 or pkt_valid=0 -> stay, address register unchanged.
REQ-023 WAIT_TILL_EMPTY: fifo_empty of latched address =1 -> LOAD_FIRST_DATA, else stay.
REQ-024 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
REQ-025 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay; fifo_full has priority when both occur.
REQ-026 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
REQ-027 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-028 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-029 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
REQ-030 soft_reset of the latched address asserted in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle, overriding REQ-023..029; soft resets of other ports are ignored.
REQ-031 Priority: resetn > soft reset > normal transitions.
REQ-032 Illegal state encodings recover to DECODE_ADDRESS next cycle.

Reset
REQ-033 resetn=0 at a clock edge: state=DECODE_ADDRESS, address register=0; outputs therefore detect_add=1, all others 0, from the following cycle.
REQ-034 Reset asserted mid-packet aborts the packet without any further write_enb_reg pulse.

Structure
REQ-035 Shared package router_pkg holds the state enum, port-count constant 3 and address constants 2'b00/01/10 plus illegal 2'b11.
REQ-036 Single flat module; no sub-module: next-state, state register, address register, output decode.

Verification
REQ-037 Empty FIFO 1, header data_in=1, pkt_valid high 4 cycles -> DECODE, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; write_enb_reg high 4 cycles.
REQ-038 fifo_empty_2=0, header data_in=2 -> WAIT_TILL_EMPTY, busy=1 until fifo_empty_2 rises, then LFD next cycle.
REQ-039 fifo_full=1 during LOAD_DATA for 3 cycles -> full_state=1 for 3 cycles, then LAF; low_pkt_valid=1 -> LOAD_PARITY.
REQ-040 soft_reset_0 pulse while in WAIT_TILL_EMPTY for port 0 -> DECODE_ADDRESS next cycle; soft_reset_1 pulse instead -> no effect.
REQ-041 data_in=3 with pkt_valid=1 -> remains DECODE_ADDRESS, busy=0.
REQ-042 resetn=0 during LOAD_DATA -> DECODE_ADDRESS next cycle, write_enb_reg=0.
